rob_dispatch: RTL and testbench

Issue-side counterpart of the reorder buffer's allocation port. It accepts one decoded instruction at a time from the decode stage and allocates a ROB entry through the to_rob / received handshake. It resolves rs1/rs2 operands via the regfile rename status and the ROB readiness lookup, updates the regfile rename table, and hands a tagged, operand-resolved packet to the reservation stations.

---
 rtl/rob_dispatch_pkg.sv | 21 ++
 rtl/rob_dispatch_operand_resolve.sv | 30 +++
 rtl/rob_dispatch.sv | 195 +++++++++++++++++++
 tb/tb_rob_dispatch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_dispatch_pkg.sv
// Shared widths, FSM encoding and the held-instruction record for the ROB dispatch stage.
package rob_dispatch_pkg;
  localparam int REG_ID_BIT    = 5;
  localparam int ROB_WIDTH_BIT = 4;
  localparam int OP_BIT        = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_BIT-1:0]     op;
    logic [REG_ID_BIT-1:0] rd;
    logic [REG_ID_BIT-1:0] rs1;
    logic [REG_ID_BIT-1:0] rs2;
    logic [31:0]           imm;
    logic [31:0]           pc;
  } dec_hold_t;
endpackage

// File: rtl/rob_dispatch_operand_resolve.sv
// Resolves one source operand: x0, committed regfile value, ROB-forwarded value, or pending tag.
module rob_dispatch_operand_resolve
  import rob_dispatch_pkg::*;
(
  input  logic [REG_ID_BIT-1:0]    rs_id,
  input  logic                     rf_busy,
  input  logic [ROB_WIDTH_BIT-1:0] rf_tag,
  input  logic [31:0]              rf_value,
  input  logic                     rob_ready,
  input  logic [31:0]              rob_value,
  output logic [31:0]              v,
  output logic                     q_valid,
  output logic [ROB_WIDTH_BIT-1:0] q
);
  always_comb begin
    v       = '0;
    q_valid = 1'b0;
    q       = '0;
    if (rs_id == '0) begin
      v = '0;
    end else if (!rf_busy) begin
      v = rf_value;
    end else if (rob_ready) begin
      v = rob_value;
    end else begin
      q_valid = 1'b1;
      q       = rf_tag;
    end
  end
endmodule

// File: rtl/rob_dispatch.sv
// Single-instruction dispatch: allocate a ROB entry, rename rd, then issue a resolved packet to the RS.
module rob_dispatch
  import rob_dispatch_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  logic [OP_BIT-1:0]        dec_op,
  input  logic [REG_ID_BIT-1:0]    dec_rd,
  input  logic [REG_ID_BIT-1:0]    dec_rs1,
  input  logic [REG_ID_BIT-1:0]    dec_rs2,
  input  logic [31:0]              dec_imm,
  input  logic [31:0]              dec_pc,
  output logic                     to_rob,
  output logic [31:0]              rob_pc,
  output logic [OP_BIT-1:0]        rob_op_type,
  output logic [REG_ID_BIT-1:0]    rob_rd,
  output logic [REG_ID_BIT-1:0]    rob_rs1,
  output logic [REG_ID_BIT-1:0]    rob_rs2,
  output logic [31:0]              rob_imm,
  output logic [31:0]              rob_inst_pc,
  input  logic                     rob_full,
  input  logic [ROB_WIDTH_BIT-1:0] rob_free_id,
  input  logic                     received,
  input  logic                     rf_rs1_busy,
  input  logic                     rf_rs2_busy,
  input  logic [ROB_WIDTH_BIT-1:0] rf_rs1_tag,
  input  logic [ROB_WIDTH_BIT-1:0] rf_rs2_tag,
  input  logic [31:0]              rf_rs1_value,
  input  logic [31:0]              rf_rs2_value,
  output logic [REG_ID_BIT-1:0]    rf_rs1_id,
  output logic [REG_ID_BIT-1:0]    rf_rs2_id,
  output logic [ROB_WIDTH_BIT-1:0] rob_query_1,
  output logic [ROB_WIDTH_BIT-1:0] rob_query_2,
  input  logic                     rob_rs1_is_ready,
  input  logic                     rob_rs2_is_ready,
  input  logic [31:0]              rob_rs1_value,
  input  logic [31:0]              rob_rs2_value,
  output logic                     rename_valid,
  output logic [REG_ID_BIT-1:0]    rename_rd,
  output logic [ROB_WIDTH_BIT-1:0] rename_tag,
  output logic                     rs_valid,
  output logic [OP_BIT-1:0]        rs_op,
  output logic [31:0]              rs_imm,
  output logic [31:0]              rs_pc,
  output logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
  output logic [31:0]              rs_vj,
  output logic [31:0]              rs_vk,
  output logic                     rs_qj_valid,
  output logic                     rs_qk_valid,
  output logic [ROB_WIDTH_BIT-1:0] rs_qj,
  output logic [ROB_WIDTH_BIT-1:0] rs_qk
);
  state_e                   state_q, state_d;
  dec_hold_t                hold_q, hold_d;
  logic                     to_rob_q, to_rob_d;
  logic                     rename_valid_q, rename_valid_d;
  logic [REG_ID_BIT-1:0]    rename_rd_q, rename_rd_d;
  logic [ROB_WIDTH_BIT-1:0] rename_tag_q, rename_tag_d;
  logic                     rs_valid_q, rs_valid_d;
  logic [ROB_WIDTH_BIT-1:0] rs_rob_id_q, rs_rob_id_d;
  logic [31:0]              vj_q, vj_d, vk_q, vk_d;
  logic                     qj_valid_q, qj_valid_d, qk_valid_q, qk_valid_d;
  logic [ROB_WIDTH_BIT-1:0] qj_q, qj_d, qk_q, qk_d;

  logic [31:0]              res_vj, res_vk;
  logic                     res_qj_valid, res_qk_valid;
  logic [ROB_WIDTH_BIT-1:0] res_qj, res_qk;

  rob_dispatch_operand_resolve u_res_rs1 (
    .rs_id(hold_q.rs1), .rf_busy(rf_rs1_busy), .rf_tag(rf_rs1_tag), .rf_value(rf_rs1_value),
    .rob_ready(rob_rs1_is_ready), .rob_value(rob_rs1_value),
    .v(res_vj), .q_valid(res_qj_valid), .q(res_qj)
  );

  rob_dispatch_operand_resolve u_res_rs2 (
    .rs_id(hold_q.rs2), .rf_busy(rf_rs2_busy), .rf_tag(rf_rs2_tag), .rf_value(rf_rs2_value),
    .rob_ready(rob_rs2_is_ready), .rob_value(rob_rs2_value),
    .v(res_vk), .q_valid(res_qk_valid), .q(res_qk)
  );

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    to_rob_d       = 1'b0;
    rename_valid_d = 1'b0;
    rename_rd_d    = rename_rd_q;
    rename_tag_d   = rename_tag_q;
    rs_valid_d     = 1'b0;
    rs_rob_id_d    = rs_rob_id_q;
    vj_d           = vj_q;
    vk_d           = vk_q;
    qj_valid_d     = qj_valid_q;
    qk_valid_d     = qk_valid_q;
    qj_d           = qj_q;
    qk_d           = qk_q;
    if (flush_in) begin
      state_d    = IDLE;
      qj_valid_d = 1'b0;
      qk_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (dec_valid) begin
          hold_d  = '{op: dec_op, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, imm: dec_imm, pc: dec_pc};
          state_d = SEND;
        end
        SEND: if (!rob_full) begin
          to_rob_d       = 1'b1;
          rs_rob_id_d    = rob_free_id;
          rename_valid_d = (hold_q.rd != '0);
          rename_rd_d    = hold_q.rd;
          rename_tag_d   = rob_free_id;
          vj_d           = res_vj;
          vk_d           = res_vk;
          qj_valid_d     = res_qj_valid;
          qk_valid_d     = res_qk_valid;
          qj_d           = res_qj;
          qk_d           = res_qk;
          state_d        = WAIT;
        end
        WAIT: if (received) begin
          rs_valid_d = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A low rdy_in freezes everything, including any pulse that happens to be high.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      to_rob_q       <= 1'b0;
      rename_valid_q <= 1'b0;
      rename_rd_q    <= '0;
      rename_tag_q   <= '0;
      rs_valid_q     <= 1'b0;
      rs_rob_id_q    <= '0;
      vj_q           <= '0;
      vk_q           <= '0;
      qj_valid_q     <= 1'b0;
      qk_valid_q     <= 1'b0;
      qj_q           <= '0;
      qk_q           <= '0;
    end else if (rdy_in) begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      to_rob_q       <= to_rob_d;
      rename_valid_q <= rename_valid_d;
      rename_rd_q    <= rename_rd_d;
      rename_tag_q   <= rename_tag_d;
      rs_valid_q     <= rs_valid_d;
      rs_rob_id_q    <= rs_rob_id_d;
      vj_q           <= vj_d;
      vk_q           <= vk_d;
      qj_valid_q     <= qj_valid_d;
      qk_valid_q     <= qk_valid_d;
      qj_q           <= qj_d;
      qk_q           <= qk_d;
    end
  end

  assign dec_ready    = (state_q == IDLE) && !flush_in;
  assign to_rob       = to_rob_q;
  assign rob_pc       = hold_q.pc;
  assign rob_inst_pc  = hold_q.pc;
  assign rob_op_type  = hold_q.op;
  assign rob_rd       = hold_q.rd;
  assign rob_rs1      = hold_q.rs1;
  assign rob_rs2      = hold_q.rs2;
  assign rob_imm      = hold_q.imm;
  assign rf_rs1_id    = hold_q.rs1;
  assign rf_rs2_id    = hold_q.rs2;
  assign rob_query_1  = rf_rs1_tag;
  assign rob_query_2  = rf_rs2_tag;
  assign rename_valid = rename_valid_q;
  assign rename_rd    = rename_rd_q;
  assign rename_tag   = rename_tag_q;
  assign rs_valid     = rs_valid_q;
  assign rs_op        = hold_q.op;
  assign rs_imm       = hold_q.imm;
  assign rs_pc        = hold_q.pc;
  assign rs_rob_id    = rs_rob_id_q;
  assign rs_vj        = vj_q;
  assign rs_vk        = vk_q;
  assign rs_qj_valid  = qj_valid_q;
  assign rs_qk_valid  = qk_valid_q;
  assign rs_qj        = qj_q;
  assign rs_qk        = qk_q;
endmodule

// File: tb/tb_rob_dispatch.sv
// Directed bench for rob_dispatch: allocation, stalls, operand forwarding, flush, pause and async reset.
module tb_rob_dispatch;
  import rob_dispatch_pkg::*;

  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0;
  logic dec_valid = 1'b0, dec_ready;
  logic [OP_BIT-1:0] dec_op = '0;
  logic [REG_ID_BIT-1:0] dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
  logic [31:0] dec_imm = '0, dec_pc = '0;
  logic to_rob;
  logic [31:0] rob_pc, rob_imm, rob_inst_pc;
  logic [OP_BIT-1:0] rob_op_type;
  logic [REG_ID_BIT-1:0] rob_rd, rob_rs1, rob_rs2;
  logic rob_full = 1'b0, received = 1'b0;
  logic [ROB_WIDTH_BIT-1:0] rob_free_id = '0;
  logic rf_rs1_busy = 1'b0, rf_rs2_busy = 1'b0;
  logic [ROB_WIDTH_BIT-1:0] rf_rs1_tag = '0, rf_rs2_tag = '0;
  logic [31:0] rf_rs1_value = '0, rf_rs2_value = '0;
  logic [REG_ID_BIT-1:0] rf_rs1_id, rf_rs2_id;
  logic [ROB_WIDTH_BIT-1:0] rob_query_1, rob_query_2;
  logic rob_rs1_is_ready = 1'b0, rob_rs2_is_ready = 1'b0;
  logic [31:0] rob_rs1_value = '0, rob_rs2_value = '0;
  logic rename_valid;
  logic [REG_ID_BIT-1:0] rename_rd;
  logic [ROB_WIDTH_BIT-1:0] rename_tag;
  logic rs_valid;
  logic [OP_BIT-1:0] rs_op;
  logic [31:0] rs_imm, rs_pc, rs_vj, rs_vk;
  logic [ROB_WIDTH_BIT-1:0] rs_rob_id, rs_qj, rs_qk;
  logic rs_qj_valid, rs_qk_valid;

  int tests = 0;
  int fails = 0;

  rob_dispatch dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op), .dec_rd(dec_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_imm(dec_imm), .dec_pc(dec_pc),
    .to_rob(to_rob), .rob_pc(rob_pc), .rob_op_type(rob_op_type), .rob_rd(rob_rd),
    .rob_rs1(rob_rs1), .rob_rs2(rob_rs2), .rob_imm(rob_imm), .rob_inst_pc(rob_inst_pc),
    .rob_full(rob_full), .rob_free_id(rob_free_id), .received(received),
    .rf_rs1_busy(rf_rs1_busy), .rf_rs2_busy(rf_rs2_busy), .rf_rs1_tag(rf_rs1_tag),
    .rf_rs2_tag(rf_rs2_tag), .rf_rs1_value(rf_rs1_value), .rf_rs2_value(rf_rs2_value),
    .rf_rs1_id(rf_rs1_id), .rf_rs2_id(rf_rs2_id), .rob_query_1(rob_query_1),
    .rob_query_2(rob_query_2), .rob_rs1_is_ready(rob_rs1_is_ready),
    .rob_rs2_is_ready(rob_rs2_is_ready), .rob_rs1_value(rob_rs1_value),
    .rob_rs2_value(rob_rs2_value), .rename_valid(rename_valid), .rename_rd(rename_rd),
    .rename_tag(rename_tag), .rs_valid(rs_valid), .rs_op(rs_op), .rs_imm(rs_imm),
    .rs_pc(rs_pc), .rs_rob_id(rs_rob_id), .rs_vj(rs_vj), .rs_vk(rs_vk),
    .rs_qj_valid(rs_qj_valid), .rs_qk_valid(rs_qk_valid), .rs_qj(rs_qj), .rs_qk(rs_qk)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [OP_BIT-1:0] op, input logic [REG_ID_BIT-1:0] rd,
                       input logic [REG_ID_BIT-1:0] rs1, input logic [REG_ID_BIT-1:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc);
    dec_op = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2; dec_imm = imm; dec_pc = pc;
    dec_valid = 1'b1;
    tick();
    dec_valid = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_to_rob", to_rob, 0);
    check("rst_rename_valid", rename_valid, 0);
    check("rst_rs_valid", rs_valid, 0);
    check("rst_rs_vj", rs_vj, 0);
    check("rst_dec_ready", dec_ready, 1);
    tick();
    tick();
    rst_in = 1'b1;

    // add x3,x1,x2 with committed operands 5/7, tag 4
    dec_op = 6'h01; dec_rd = 5'd3; dec_rs1 = 5'd1; dec_rs2 = 5'd2;
    dec_imm = 32'h10; dec_pc = 32'h100; dec_valid = 1'b1;
    #1;
    check("t1_dec_ready_idle", dec_ready, 1);
    tick();
    dec_valid = 1'b0;
    check("t1_dec_ready_send", dec_ready, 0);
    check("t1_rf_rs1_id", rf_rs1_id, 1);
    check("t1_rf_rs2_id", rf_rs2_id, 2);
    rf_rs1_value = 32'd5; rf_rs2_value = 32'd7; rob_free_id = 4'd4;
    tick();
    check("t1_to_rob", to_rob, 1);
    check("t1_rob_rd", rob_rd, 3);
    check("t1_rob_pc", rob_pc, 32'h100);
    check("t1_rename_valid", rename_valid, 1);
    check("t1_rename_rd", rename_rd, 3);
    check("t1_rename_tag", rename_tag, 4);
    check("t1_rs_valid_early", rs_valid, 0);
    tick();
    check("t1_to_rob_drop", to_rob, 0);
    check("t1_rename_drop", rename_valid, 0);
    received = 1'b1;
    tick();
    received = 1'b0;
    check("t1_rs_valid", rs_valid, 1);
    check("t1_vj", rs_vj, 5);
    check("t1_vk", rs_vk, 7);
    check("t1_qj_valid", rs_qj_valid, 0);
    check("t1_qk_valid", rs_qk_valid, 0);
    check("t1_rob_id", rs_rob_id, 4);
    check("t1_rs_op", rs_op, 1);
    check("t1_rs_imm", rs_imm, 32'h10);
    tick();
    check("t1_rs_valid_drop", rs_valid, 0);
    $display("[TB] txn1 add x3,x1,x2 done");

    // ROB full for three cycles, then a single allocation pulse
    rob_full = 1'b1;
    issue(6'h02, 5'd4, 5'd0, 5'd0, 32'h0, 32'h104);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_full_to_rob", to_rob, 0);
      check("t2_full_dec_ready", dec_ready, 0);
    end
    rob_full = 1'b0; rob_free_id = 4'd5;
    tick();
    check("t2_to_rob", to_rob, 1);
    check("t2_rename_tag", rename_tag, 5);
    tick();
    check("t2_to_rob_single", to_rob, 0);
    received = 1'b1;
    tick();
    received = 1'b0;
    check("t2_rs_valid", rs_valid, 1);
    check("t2_rob_id", rs_rob_id, 5);
    $display("[TB] txn2 rob_full stall done");

    // rs1 forwarded from ready ROB entry 2; rs2 pending on tag 3
    issue(6'h03, 5'd8, 5'd6, 5'd7, 32'h0, 32'h108);
    rf_rs1_busy = 1'b1; rf_rs1_tag = 4'd2; rf_rs1_value = 32'hdead;
    rob_rs1_is_ready = 1'b1; rob_rs1_value = 32'h55;
    rf_rs2_busy = 1'b1; rf_rs2_tag = 4'd3; rob_rs2_is_ready = 1'b0; rob_rs2_value = 32'h77;
    rob_free_id = 4'd9;
    #1;
    check("t3_query1", rob_query_1, 2);
    check("t3_query2", rob_query_2, 3);
    tick();
    check("t3_rename_rd", rename_rd, 8);
    check("t3_rename_tag", rename_tag, 9);
    rf_rs1_busy = 1'b0; rf_rs2_busy = 1'b0; rob_rs1_is_ready = 1'b0;
    tick();
    received = 1'b1;
    tick();
    received = 1'b0;
    check("t3_rs_valid", rs_valid, 1);
    check("t3_vj", rs_vj, 32'h55);
    check("t3_qj_valid", rs_qj_valid, 0);
    check("t3_vk", rs_vk, 0);
    check("t3_qk_valid", rs_qk_valid, 1);
    check("t3_qk", rs_qk, 3);
    check("t3_rob_id", rs_rob_id, 9);
    $display("[TB] txn3 forward/pending done");

    // rd=x0 and rs1=x0: no rename, x0 reads as zero
    issue(6'h04, 5'd0, 5'd0, 5'd5, 32'h0, 32'h10c);
    rf_rs1_value = 32'h99; rf_rs2_value = 32'h22; rob_free_id = 4'd10;
    tick();
    check("t4_to_rob", to_rob, 1);
    check("t4_no_rename", rename_valid, 0);
    tick();
    received = 1'b1;
    tick();
    received = 1'b0;
    check("t4_rs_valid", rs_valid, 1);
    check("t4_vj_zero", rs_vj, 0);
    check("t4_vk", rs_vk, 32'h22);
    check("t4_qk_valid", rs_qk_valid, 0);
    $display("[TB] txn4 x0 handling done");

    // flush in WAIT discards the later received
    issue(6'h05, 5'd9, 5'd1, 5'd2, 32'h0, 32'h110);
    rf_rs2_busy = 1'b1; rf_rs2_tag = 4'd6; rob_free_id = 4'd11;
    tick();
    check("t5_to_rob", to_rob, 1);
    check("t5_qk_valid_set", rs_qk_valid, 1);
    rf_rs2_busy = 1'b0;
    tick();
    flush_in = 1'b1;
    #1;
    check("t5_dec_ready_flush", dec_ready, 0);
    tick();
    check("t5_qk_valid_flushed", rs_qk_valid, 0);
    flush_in = 1'b0; received = 1'b1;
    #1;
    check("t5_dec_ready_after", dec_ready, 1);
    tick();
    received = 1'b0;
    check("t5_no_rs_valid", rs_valid, 0);
    $display("[TB] txn5 flush in WAIT done");

    // pause during WAIT holds pulses and ignores received
    issue(6'h06, 5'd10, 5'd1, 5'd2, 32'h0, 32'h114);
    rf_rs1_value = 32'd1; rf_rs2_value = 32'd2; rob_free_id = 4'd12;
    tick();
    check("t6_to_rob", to_rob, 1);
    rdy_in = 1'b0;
    tick();
    tick();
    check("t6_to_rob_held", to_rob, 1);
    check("t6_rename_held", rename_valid, 1);
    received = 1'b1;
    tick();
    check("t6_no_rs_valid_paused", rs_valid, 0);
    rdy_in = 1'b1; received = 1'b0;
    tick();
    check("t6_to_rob_drop", to_rob, 0);
    received = 1'b1;
    tick();
    received = 1'b0;
    check("t6_rs_valid", rs_valid, 1);
    check("t6_vk", rs_vk, 2);
    check("t6_rob_id", rs_rob_id, 12);
    tick();
    $display("[TB] txn6 pause done");

    // asynchronous reset while stalled in SEND
    rob_full = 1'b1;
    issue(6'h07, 5'd11, 5'd3, 5'd4, 32'h0, 32'h118);
    tick();
    check("t7_to_rob_stalled", to_rob, 0);
    #3;
    rst_in = 1'b0;
    #1;
    check("t7_async_vj", rs_vj, 0);
    check("t7_async_rename_tag", rename_tag, 0);
    check("t7_async_rs1_id", rf_rs1_id, 0);
    check("t7_async_dec_ready", dec_ready, 1);
    rob_full = 1'b0;
    tick();
    check("t7_to_rob_in_reset", to_rob, 0);
    #3;
    rst_in = 1'b1;
    tick();
    check("t7_to_rob_after", to_rob, 0);
    $display("[TB] txn7 async reset done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
